// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array PE: dataflow encoding, OS drain
// states and width-generic signed arithmetic helpers.
package sa_pkg;

  localparam logic DF_WS = 1'b0;
  localparam logic DF_OS = 1'b1;

  // Widest accumulator the helpers below can carry.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_EMIT = 2'd1,
    ST_FWD  = 2'd2
  } os_state_e;

  // Sign-extend the low w bits of v to MAX_W bits.
  function automatic logic signed [MAX_W-1:0] sext(input logic [MAX_W-1:0] v,
                                                   input int w);
    logic signed [MAX_W-1:0] t;
    t = signed'(v << (MAX_W - w));
    return t >>> (MAX_W - w);
  endfunction

  // Operands are sign-extended acc_w-bit values; the caller keeps the low acc_w
  // bits, so returning the raw sum wraps and returning a bound saturates.
  function automatic logic signed [MAX_W-1:0] sat_add(input logic signed [MAX_W-1:0] a,
                                                      input logic signed [MAX_W-1:0] b,
                                                      input int acc_w,
                                                      input logic sat);
    logic signed [MAX_W:0] sum;
    logic signed [MAX_W:0] hi;
    logic signed [MAX_W:0] lo;
    sum = (MAX_W+1)'(a) + (MAX_W+1)'(b);
    hi  = ((MAX_W+1)'(1) <<< (acc_w - 1)) - (MAX_W+1)'(1);
    lo  = -hi - (MAX_W+1)'(1);
    if (sat && (sum > hi)) return hi[MAX_W-1:0];
    if (sat && (sum < lo)) return lo[MAX_W-1:0];
    return sum[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/sa_pe_mul.sv
// Signed DATA_W x DATA_W multiplier with MUL_STAGES output registers and a
// matching valid pipe that can be flushed without disturbing the data.
module sa_pe_mul #(
  parameter int DATA_W     = 16,
  parameter int MUL_STAGES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_valid,
  input  logic signed [DATA_W-1:0]   i_a,
  input  logic signed [DATA_W-1:0]   i_b,
  output logic                       o_valid,
  output logic signed [2*DATA_W-1:0] o_prod
);

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0] w_prod;

  assign w_prod = PW'(i_a) * PW'(i_b);

  if (MUL_STAGES == 0) begin : g_comb
    assign o_valid = i_valid;
    assign o_prod  = w_prod;
  end else begin : g_pipe
    logic signed [PW-1:0]  r_prod [MUL_STAGES];
    logic [MUL_STAGES-1:0] r_valid;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_valid <= '0;
        // NOTE: these are a handful of flops rather than a RAM, so they take the reset too.
        for (int i = 0; i < MUL_STAGES; i++) r_prod[i] <= '0;
      end else begin
        // NOTE: non-blocking, so every stage samples its predecessor's pre-edge value.
        r_valid[0] <= i_valid & ~i_flush;
        r_prod[0]  <= w_prod;
        for (int i = 1; i < MUL_STAGES; i++) begin
          r_valid[i] <= r_valid[i-1] & ~i_flush;
          r_prod[i]  <= r_prod[i-1];
        end
      end
    end

    assign o_valid = r_valid[MUL_STAGES-1];
    assign o_prod  = r_prod[MUL_STAGES-1];
  end

endmodule

// File: rtl/sa_pe_dbuf.sv
// Systolic-array PE: signed MAC with double-buffered weights, runtime
// weight-stationary / output-stationary dataflow and a column drain FSM.
module sa_pe_dbuf
  import sa_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 32,
  parameter int MUL_STAGES = 1,
  parameter int SAT        = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_dataflow,
  input  logic              i_w_valid,
  input  logic [DATA_W-1:0] i_w_data,
  input  logic              i_w_swap,
  output logic              o_w_valid,
  output logic [DATA_W-1:0] o_w_data,
  output logic              o_w_swap,
  input  logic              i_left_valid,
  input  logic [DATA_W-1:0] i_left_data,
  output logic              o_right_valid,
  output logic [DATA_W-1:0] o_right_data,
  input  logic              i_top_valid,
  input  logic [ACC_W-1:0]  i_top_data,
  output logic              o_bot_valid,
  output logic [ACC_W-1:0]  o_bot_data,
  input  logic              i_os_drain
);

  localparam logic SAT_EN = (SAT != 0);

  logic [DATA_W-1:0]        r_shadow;
  logic signed [DATA_W-1:0] r_active;
  logic                     r_w_valid;
  logic [DATA_W-1:0]        r_w_data;
  logic                     r_w_swap;
  logic                     r_right_valid;
  logic [DATA_W-1:0]        r_right_data;
  logic                     r_bot_valid;
  logic [ACC_W-1:0]         r_bot_data;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_df;
  os_state_e                r_state;

  logic                      w_is_os;
  logic                      w_df_chg;
  logic signed [DATA_W-1:0]  w_mul_b;
  logic                      w_mul_v_in;
  logic                      w_mul_valid;
  logic signed [2*DATA_W-1:0] w_mul_prod;
  logic                      w_prod_valid;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_prod_add;
  logic signed [ACC_W-1:0]   w_addend;
  logic signed [ACC_W-1:0]   w_top_al;
  logic signed [ACC_W-1:0]   w_sum_ws;
  logic signed [ACC_W-1:0]   w_sum_acc;
  os_state_e                 w_state_nxt;
  logic signed [ACC_W-1:0]   w_acc_nxt;
  logic                      w_bot_valid_nxt;
  logic [ACC_W-1:0]          w_bot_data_nxt;

  assign w_is_os  = (i_dataflow == DF_OS);
  assign w_df_chg = (i_dataflow != r_df);

  // Weight shift chain, double buffer and activation pass-through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow      <= '0;
      r_active      <= '0;
      r_w_valid     <= 1'b0;
      r_w_data      <= '0;
      r_w_swap      <= 1'b0;
      r_right_valid <= 1'b0;
      r_right_data  <= '0;
    end else begin
      r_w_valid     <= i_w_valid;
      r_w_swap      <= i_w_swap;
      r_right_valid <= i_left_valid;
      r_right_data  <= i_left_data;
      if (i_w_valid) begin
        r_shadow <= i_w_data;
        r_w_data <= r_shadow;
      end
      // A swap coinciding with a load commits the incoming weight directly.
      if (i_w_swap) r_active <= i_w_valid ? i_w_data : r_shadow;
    end
  end

  assign w_mul_b    = w_is_os ? i_top_data[DATA_W-1:0] : r_active;
  assign w_mul_v_in = i_left_valid & (~w_is_os | i_top_valid);

  sa_pe_mul #(
    .DATA_W    (DATA_W),
    .MUL_STAGES(MUL_STAGES)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .i_flush(w_df_chg),
    .i_valid(w_mul_v_in),
    .i_a    (i_left_data),
    .i_b    (w_mul_b),
    .o_valid(w_mul_valid),
    .o_prod (w_mul_prod)
  );

  assign w_prod_valid = w_mul_valid & ~w_df_chg;
  assign w_prod_ext   = ACC_W'(sext(MAX_W'(unsigned'(w_mul_prod)), 2 * DATA_W));
  assign w_prod_add   = w_prod_valid ? w_prod_ext : '0;
  assign w_addend     = i_top_valid ? i_top_data : '0;

  // The WS psum addend rides alongside the multiplier so both arrive together.
  if (MUL_STAGES == 0) begin : g_top_comb
    assign w_top_al = w_addend;
  end else begin : g_top_pipe
    logic signed [ACC_W-1:0] r_top [MUL_STAGES];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < MUL_STAGES; i++) r_top[i] <= '0;
      end else begin
        r_top[0] <= w_addend;
        for (int i = 1; i < MUL_STAGES; i++) r_top[i] <= r_top[i-1];
      end
    end

    assign w_top_al = r_top[MUL_STAGES-1];
  end

  assign w_sum_ws  = ACC_W'(sat_add(MAX_W'(w_top_al), MAX_W'(w_prod_ext), ACC_W, SAT_EN));
  assign w_sum_acc = ACC_W'(sat_add(MAX_W'(r_acc), MAX_W'(w_prod_add), ACC_W, SAT_EN));

  always_comb begin
    // NOTE: defaults first, so no branch leaves a variable unassigned and infers a latch.
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_bot_valid_nxt = 1'b0;
    w_bot_data_nxt  = r_bot_data;

    if (!w_is_os) begin
      w_state_nxt = ST_RUN;
      if (w_prod_valid) begin
        w_bot_valid_nxt = 1'b1;
        w_bot_data_nxt  = w_sum_ws;
      end
    end else begin
      case (r_state)
        ST_EMIT: begin
          w_bot_valid_nxt = 1'b1;
          w_bot_data_nxt  = w_sum_acc;
          w_acc_nxt       = '0;
          w_state_nxt     = i_os_drain ? ST_FWD : ST_RUN;
        end
        ST_FWD: begin
          w_bot_valid_nxt = i_top_valid;
          w_bot_data_nxt  = i_top_data;
          w_acc_nxt       = w_sum_acc;
          if (!i_os_drain) w_state_nxt = ST_RUN;
        end
        default: begin
          w_bot_valid_nxt = i_top_valid;
          w_bot_data_nxt  = i_top_data;
          w_acc_nxt       = w_sum_acc;
          if (i_os_drain) w_state_nxt = ST_EMIT;
        end
      endcase
    end

    // Switching dataflow discards any partial OS result.
    if (w_df_chg) begin
      w_state_nxt = ST_RUN;
      w_acc_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_acc       <= '0;
      r_bot_valid <= 1'b0;
      r_bot_data  <= '0;
      r_df        <= DF_WS;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_bot_valid <= w_bot_valid_nxt;
      r_bot_data  <= w_bot_data_nxt;
      r_df        <= i_dataflow;
    end
  end

  assign o_w_valid     = r_w_valid;
  assign o_w_data      = r_w_data;
  assign o_w_swap      = r_w_swap;
  assign o_right_valid = r_right_valid;
  assign o_right_data  = r_right_data;
  assign o_bot_valid   = r_bot_valid;
  assign o_bot_data    = r_bot_data;

endmodule

// File: tb/tb_sa_pe_dbuf.sv
// Self-checking bench for sa_pe_dbuf: wrap and saturating instances side by side,
// directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_sa_pe_dbuf;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int MS     = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic              i_dataflow   = 1'b0;
  logic              i_w_valid    = 1'b0;
  logic [DATA_W-1:0] i_w_data     = '0;
  logic              i_w_swap     = 1'b0;
  logic              i_left_valid = 1'b0;
  logic [DATA_W-1:0] i_left_data  = '0;
  logic              i_top_valid  = 1'b0;
  logic [ACC_W-1:0]  i_top_data   = '0;
  logic              i_os_drain   = 1'b0;

  logic              w_valid_o [2];
  logic [DATA_W-1:0] w_data_o  [2];
  logic              w_swap_o  [2];
  logic              right_v   [2];
  logic [DATA_W-1:0] right_d   [2];
  logic              bot_v     [2];
  logic [ACC_W-1:0]  bot_d     [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sa_pe_dbuf #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MUL_STAGES(MS), .SAT(0)) u_dut_wrap (
    .clk(clk), .rst(rst), .i_dataflow(i_dataflow),
    .i_w_valid(i_w_valid), .i_w_data(i_w_data), .i_w_swap(i_w_swap),
    .o_w_valid(w_valid_o[0]), .o_w_data(w_data_o[0]), .o_w_swap(w_swap_o[0]),
    .i_left_valid(i_left_valid), .i_left_data(i_left_data),
    .o_right_valid(right_v[0]), .o_right_data(right_d[0]),
    .i_top_valid(i_top_valid), .i_top_data(i_top_data),
    .o_bot_valid(bot_v[0]), .o_bot_data(bot_d[0]), .i_os_drain(i_os_drain)
  );

  sa_pe_dbuf #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MUL_STAGES(MS), .SAT(1)) u_dut_sat (
    .clk(clk), .rst(rst), .i_dataflow(i_dataflow),
    .i_w_valid(i_w_valid), .i_w_data(i_w_data), .i_w_swap(i_w_swap),
    .o_w_valid(w_valid_o[1]), .o_w_data(w_data_o[1]), .o_w_swap(w_swap_o[1]),
    .i_left_valid(i_left_valid), .i_left_data(i_left_data),
    .o_right_valid(right_v[1]), .o_right_data(right_d[1]),
    .i_top_valid(i_top_valid), .i_top_data(i_top_data),
    .o_bot_valid(bot_v[1]), .o_bot_data(bot_d[1]), .i_os_drain(i_os_drain)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit     v;
    longint p;
    longint add;
  } pipe_t;

  pipe_t  m_pipe[$];
  longint m_shadow, m_active;
  longint m_acc [2];
  bit     m_prev_df, m_emit, m_fwd;

  bit                e_w_valid, e_w_swap, e_right_v, e_bot_v;
  logic [DATA_W-1:0] e_w_data, e_right_d;
  longint            e_bot [2];

  function automatic longint acc_add(longint a, longint b, int sat);
    longint s;
    longint hi;
    longint lo;
    s  = a + b;
    hi = (longint'(1) <<< (ACC_W - 1)) - 1;
    lo = -hi - 1;
    if (sat != 0) begin
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
    end
    return longint'($signed(32'(s)));
  endfunction

  task automatic model_reset();
    pipe_t z;
    z.v = 0; z.p = 0; z.add = 0;
    m_pipe.delete();
    for (int i = 0; i < MS; i++) m_pipe.push_back(z);
    m_shadow = 0; m_active = 0; m_prev_df = 0; m_emit = 0; m_fwd = 0;
    e_w_valid = 0; e_w_swap = 0; e_right_v = 0; e_bot_v = 0;
    e_w_data = '0; e_right_d = '0;
    for (int s = 0; s < 2; s++) begin m_acc[s] = 0; e_bot[s] = 0; end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit     os, chg;
    pipe_t  nw, c;
    longint p_in;
    os  = i_dataflow;
    chg = (i_dataflow != m_prev_df);
    m_prev_df = i_dataflow;

    nw.v   = i_left_valid && (!os || i_top_valid);
    nw.p   = longint'($signed(i_left_data)) *
             (os ? longint'($signed(i_top_data[DATA_W-1:0])) : m_active);
    nw.add = i_top_valid ? longint'($signed(i_top_data)) : 0;
    m_pipe.push_back(nw);
    c = m_pipe.pop_front();
    if (chg) begin
      c.v = 0;
      foreach (m_pipe[i]) m_pipe[i].v = 0;
    end

    if (i_w_swap) m_active = i_w_valid ? longint'($signed(i_w_data)) : m_shadow;
    if (i_w_valid) begin
      e_w_data = 16'(m_shadow);
      m_shadow = longint'($signed(i_w_data));
    end
    e_w_valid = i_w_valid;
    e_w_swap  = i_w_swap;
    e_right_v = i_left_valid;
    e_right_d = i_left_data;

    p_in = c.v ? c.p : 0;
    if (!os) begin
      e_bot_v = c.v;
      if (c.v) for (int s = 0; s < 2; s++) e_bot[s] = acc_add(c.add, c.p, s);
    end else if (m_emit) begin
      e_bot_v = 1;
      for (int s = 0; s < 2; s++) begin
        e_bot[s] = acc_add(m_acc[s], p_in, s);
        m_acc[s] = 0;
      end
    end else begin
      e_bot_v = i_top_valid;
      for (int s = 0; s < 2; s++) begin
        e_bot[s] = longint'($signed(i_top_data));
        m_acc[s] = acc_add(m_acc[s], p_in, s);
      end
    end

    if (chg || !os) begin
      m_emit = 0;
      m_fwd  = 0;
      if (chg) for (int s = 0; s < 2; s++) m_acc[s] = 0;
    end else if (m_emit) begin
      m_emit = 0;
      m_fwd  = i_os_drain;
    end else if (m_fwd) begin
      m_fwd = i_os_drain;
    end else begin
      m_emit = i_os_drain;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    for (int s = 0; s < 2; s++) begin
      check($sformatf("w_valid[%0d]", s), 32'(w_valid_o[s]), 32'(e_w_valid));
      check($sformatf("w_data[%0d]", s), 32'(w_data_o[s]), 32'(e_w_data));
      check($sformatf("w_swap[%0d]", s), 32'(w_swap_o[s]), 32'(e_w_swap));
      check($sformatf("right_v[%0d]", s), 32'(right_v[s]), 32'(e_right_v));
      check($sformatf("right_d[%0d]", s), 32'(right_d[s]), 32'(e_right_d));
      check($sformatf("bot_v[%0d]", s), 32'(bot_v[s]), 32'(e_bot_v));
      check($sformatf("bot_d[%0d]", s), bot_d[s], 32'(e_bot[s]));
    end
  endtask

  task automatic check_reset(input string tag);
    for (int s = 0; s < 2; s++) begin
      check({tag, "_w_valid"}, 32'(w_valid_o[s]), 32'd0);
      check({tag, "_w_data"}, 32'(w_data_o[s]), 32'd0);
      check({tag, "_w_swap"}, 32'(w_swap_o[s]), 32'd0);
      check({tag, "_right_v"}, 32'(right_v[s]), 32'd0);
      check({tag, "_right_d"}, 32'(right_d[s]), 32'd0);
      check({tag, "_bot_v"}, 32'(bot_v[s]), 32'd0);
      check({tag, "_bot_d"}, bot_d[s], 32'd0);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    i_w_valid = 0; i_w_swap = 0; i_left_valid = 0; i_top_valid = 0; i_os_drain = 0;
  endtask

  task automatic drive(input bit lv, input int l, input bit tv, input int t);
    i_left_valid = lv; i_left_data = 16'(l);
    i_top_valid  = tv; i_top_data  = 32'(t);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic pulse_reset(input string tag);
    rst = 1'b0;
    #1;
    check_reset(tag);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic os_load_56();
    drive(1, 2, 1, 5); tick();
    drive(1, 3, 1, 6); tick();
    drive(1, 4, 1, 7); tick();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset("init");
    rst = 1'b1;

    // Traffic, then reset mid-stream; active weight 5 must be wiped.
    i_w_valid = 1; i_w_data = 16'd5; i_w_swap = 1; drive(1, 3, 1, 1); tick();
    idle(); drive(1, 3, 0, 0); tick();
    pulse_reset("rst_mid");
    drive(1, 9, 1, 77); tick();
    idle(); tick();
    check("rst_mac_data", bot_d[0], 32'd77);
    check("rst_mac_valid", 32'(bot_v[0]), 32'd1);

    // WS load and latency.
    i_w_valid = 1; i_w_data = 16'd3; tick();
    idle(); i_w_swap = 1; tick();
    idle(); drive(1, 5, 1, 10); tick();
    check("ws_right_d", 32'(right_d[0]), 32'd5);
    check("ws_right_v", 32'(right_v[0]), 32'd1);
    idle(); tick();
    check("ws_bot_d", bot_d[0], 32'd25);
    check("ws_bot_v", 32'(bot_v[0]), 32'd1);

    // Double buffer: shadow load does not disturb active until swap.
    i_w_valid = 1; i_w_data = 16'hFFFE; drive(1, 4, 1, 0); tick();
    i_w_valid = 0; tick();
    check("dbuf_pre0", bot_d[0], 32'd12);
    i_w_swap = 1; tick();
    check("dbuf_pre1", bot_d[0], 32'd12);
    i_w_swap = 0; tick();
    check("dbuf_pre2", bot_d[0], 32'd12);
    idle(); tick();
    check("dbuf_post", bot_d[0], 32'hFFFF_FFF8);
    i_w_valid = 1; i_w_data = 16'd7; i_w_swap = 1; tick();
    idle(); drive(1, 1, 1, 0); tick();
    idle(); tick();
    check("dbuf_wthru", bot_d[0], 32'd7);

    // OS accumulate, emit, forward.
    i_dataflow = 1; tick();
    os_load_56();
    idle(); i_os_drain = 1; tick();
    tick();
    check("os_emit_d", bot_d[0], 32'd56);
    check("os_emit_d_sat", bot_d[1], 32'd56);
    check("os_emit_v", 32'(bot_v[0]), 32'd1);
    drive(0, 0, 1, 99); tick();
    check("os_fwd_d", bot_d[0], 32'd99);
    check("os_fwd_v", 32'(bot_v[0]), 32'd1);
    idle(); tick(); tick();

    // Saturation versus wrap.
    i_dataflow = 0; tick();
    i_w_valid = 1; i_w_data = 16'h7FFF; tick();
    idle(); i_w_swap = 1; tick();
    idle(); drive(1, 32'h7FFF, 1, 32'h7FFF_FFF0); tick();
    idle(); tick();
    check("sat_wrap", bot_d[0], 32'hBFFE_FFF1);
    check("sat_clamp", bot_d[1], 32'h7FFF_FFFF);

    // Mode switch discards the OS accumulator.
    i_dataflow = 1; tick();
    os_load_56();
    idle(); tick();
    i_dataflow = 0; tick(); tick();
    i_dataflow = 1; tick();
    i_os_drain = 1; tick();
    i_os_drain = 0; tick();
    check("mode_clr_d", bot_d[0], 32'd0);
    check("mode_clr_v", 32'(bot_v[0]), 32'd1);
    idle(); tick();

    // Randomized traffic with occasional mode flips, drains and a reset.
    for (int n = 0; n < 1500; n++) begin
      i_left_valid = ($urandom_range(0, 3) != 0);
      i_left_data  = 16'($urandom);
      i_top_valid  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       i_top_data = 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
        1:       i_top_data = 32'h8000_0000 + 32'($urandom_range(0, 255));
        default: i_top_data = $urandom;
      endcase
      i_w_valid = ($urandom_range(0, 3) == 0);
      i_w_data  = 16'($urandom);
      i_w_swap  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) i_os_drain = ~i_os_drain;
      if ($urandom_range(0, 49) == 0) i_dataflow = ~i_dataflow;
      if (n == 700) pulse_reset("rst_rand");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
